// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with per-register busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       iClk,
    input  logic                       iReset,
    input  logic [NUM_RD*ADDR_W-1:0]   iRaddr,
    output logic [NUM_RD*DATA_W-1:0]   oRdata,
    output logic [NUM_RD-1:0]          oBusy,
    input  logic                       iWeA,
    input  logic [ADDR_W-1:0]          iWaddrA,
    input  logic [DATA_W-1:0]          iWdataA,
    input  logic                       iWeB,
    input  logic [ADDR_W-1:0]          iWaddrB,
    input  logic [DATA_W-1:0]          iWdataB,
    input  logic                       iIssueWe,
    input  logic [ADDR_W-1:0]          iIssueAddr,
    output logic [ADDR_W:0]            oBusyCnt
);

    localparam int   DEPTH    = 1 << ADDR_W;
    localparam logic HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    // Effective enables: with a hardwired zero register, anything aimed at r0 is dropped
    logic              w_we_a;
    logic              w_we_b;
    logic              w_issue;
    logic              w_b_collides;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_busy_cnt_nxt;

    assign w_we_a       = iWeA     && !(HAS_ZERO && (iWaddrA    == '0));
    assign w_we_b       = iWeB     && !(HAS_ZERO && (iWaddrB    == '0));
    assign w_issue      = iIssueWe && !(HAS_ZERO && (iIssueAddr == '0));
    assign w_b_collides = w_we_a && (iWaddrA == iWaddrB);

    // Next scoreboard state: completion clears first, then a new issue sets (issue wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we_b) begin
            w_busy_nxt[iWaddrB] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[iIssueAddr] = 1'b1;
        end
    end

    // Population count of the next busy vector so the count tracks the bits on the same edge
    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + (ADDR_W + 1)'(w_busy_nxt[i]);
        end
    end

    // Register storage: port B is suppressed on an address collision so port A data lands
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we_b && !w_b_collides) begin
                r_mem[iWaddrB] <= iWdataB;
            end
            if (w_we_a) begin
                r_mem[iWaddrA] <= iWdataA;
            end
        end
    end

    // Scoreboard bits and their registered population count
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    assign oBusyCnt = r_busy_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;
        logic              w_bs;

        assign w_ra = iRaddr[k*ADDR_W +: ADDR_W];

        // Combinational read; optional forwarding lets a same-cycle write bypass storage
        always_comb begin
            w_rd = r_mem[w_ra];
            if (HAS_ZERO && (w_ra == '0)) begin
                w_rd = '0;
            end
`ifdef REGFILE_BYPASS_EN
            if (w_we_b && (iWaddrB == w_ra)) begin
                w_rd = iWdataB;
            end
            if (w_we_a && (iWaddrA == w_ra)) begin
                w_rd = iWdataA;
            end
`endif
        end

        // Busy lookup; with forwarding, a completing port-B write hides the bit unless re-issued
        always_comb begin
            w_bs = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (iWeB && (iWaddrB == w_ra) && !(w_issue && (iIssueAddr == w_ra))) begin
                w_bs = 1'b0;
            end
`endif
        end

        assign oRdata[k*DATA_W +: DATA_W] = w_rd;
        assign oBusy[k]                   = w_bs;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed self-checking bench for regfile_mp
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int ZR    = 1;
    localparam int DEPTH = 1 << AW;

    logic              iClk;
    logic              iReset;
    logic [NR*AW-1:0]  iRaddr;
    logic [NR*DW-1:0]  oRdata;
    logic [NR-1:0]     oBusy;
    logic              iWeA;
    logic [AW-1:0]     iWaddrA;
    logic [DW-1:0]     iWdataA;
    logic              iWeB;
    logic [AW-1:0]     iWaddrB;
    logic [DW-1:0]     iWdataB;
    logic              iIssueWe;
    logic [AW-1:0]     iIssueAddr;
    logic [AW:0]       oBusyCnt;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR)) dut (
        .iClk(iClk), .iReset(iReset),
        .iRaddr(iRaddr), .oRdata(oRdata), .oBusy(oBusy),
        .iWeA(iWeA), .iWaddrA(iWaddrA), .iWdataA(iWdataA),
        .iWeB(iWeB), .iWaddrB(iWaddrB), .iWdataB(iWdataB),
        .iIssueWe(iIssueWe), .iIssueAddr(iIssueAddr),
        .oBusyCnt(oBusyCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_r0(input logic [AW-1:0] a);
        return (ZR != 0) && (a == 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v = is_r0(a) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (iWeA && iWaddrA == a && !is_r0(a))      v = iWdataA;
        else if (iWeB && iWaddrB == a && !is_r0(a)) v = iWdataB;
`endif
        return v;
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        logic b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (iWeB && iWaddrB == a && !(iIssueWe && iIssueAddr == a && !is_r0(a))) b = 1'b0;
`endif
        return b;
    endfunction

    // One clock: drive at negedge, compare against model, then apply the edge's effect to the model
    task automatic step(input logic we_a, input logic [AW-1:0] wa, input logic [DW-1:0] da,
                        input logic we_b, input logic [AW-1:0] wb, input logic [DW-1:0] db,
                        input logic iss, input logic [AW-1:0] ia,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(negedge iClk);
        iWeA = we_a; iWaddrA = wa; iWdataA = da;
        iWeB = we_b; iWaddrB = wb; iWdataB = db;
        iIssueWe = iss; iIssueAddr = ia;
        iRaddr = {ra1, ra0};
        #1;
        chk("rdata0", 64'(oRdata[DW-1:0]),  64'(model_rd(ra0)));
        chk("rdata1", 64'(oRdata[2*DW-1:DW]), 64'(model_rd(ra1)));
        chk("busy0",  64'(oBusy[0]), 64'(model_busy(ra0)));
        chk("busy1",  64'(oBusy[1]), 64'(model_busy(ra1)));
        chk("busycnt", 64'(oBusyCnt), 64'(model_cnt()));
        if (we_b && !is_r0(wb)) m_mem[wb] = db;
        if (we_a && !is_r0(wa)) m_mem[wa] = da;
        if (we_b) m_busy[wb] = 1'b0;
        if (iss && !is_r0(ia)) m_busy[ia] = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, ra0, ra1);
    endtask

    initial begin
        iReset = 1'b1;
        iWeA = 0; iWaddrA = '0; iWdataA = '0;
        iWeB = 0; iWaddrB = '0; iWdataB = '0;
        iIssueWe = 0; iIssueAddr = '0;
        iRaddr = {5'd7, 5'd5};
        model_reset();
        #3;
        chk("reset_rdata", 64'(oRdata), 64'h0);
        chk("reset_busy",  64'(oBusy), 64'h0);
        chk("reset_cnt",   64'(oBusyCnt), 64'h0);
        @(negedge iClk);
        iReset = 1'b0;

        // Asynchronous reset mid-cycle after loading r5
        step(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
        rd(5'd5, 5'd5);
        chk("r5_loaded", 64'(oRdata[DW-1:0]), 64'h1234);
        @(posedge iClk);
        #2;
        iReset = 1'b1;
        #1;
        chk("async_rst_r5",   64'(oRdata[DW-1:0]), 64'h0);
        chk("async_rst_busy", 64'(oBusy), 64'h0);
        chk("async_rst_cnt",  64'(oBusyCnt), 64'h0);
        model_reset();
        @(negedge iClk);
        iReset = 1'b0;

        // Two-port write, then read on both ports
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd7, 32'h0000_00FF, 1'b0, '0, 5'd0, 5'd0);
        rd(5'd3, 5'd7);
        chk("basic_r3", 64'(oRdata[DW-1:0]),    64'hDEADBEEF);
        chk("basic_r7", 64'(oRdata[2*DW-1:DW]), 64'hFF);

        // Collision on r9 while busy: A data wins, busy still cleared
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        rd(5'd9, 5'd0);
        chk("coll_busy_before", 64'(oBusy[0]), 64'h1);
        chk("coll_cnt_before",  64'(oBusyCnt), 64'h1);
        step(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 1'b0, '0, 5'd9, 5'd0);
        rd(5'd9, 5'd0);
        chk("coll_data", 64'(oRdata[DW-1:0]), 64'h11);
        chk("coll_busy", 64'(oBusy[0]), 64'h0);
        chk("coll_cnt",  64'(oBusyCnt), 64'h0);

        // Hardwired zero register ignores write and issue
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
        rd(5'd0, 5'd0);
        chk("zero_data", 64'(oRdata[DW-1:0]), 64'h0);
        chk("zero_busy", 64'(oBusy[0]), 64'h0);
        chk("zero_cnt",  64'(oBusyCnt), 64'h0);

        // Scoreboard: issue, complete-with-reissue, final complete
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 5'd0);
        rd(5'd4, 5'd0);
        chk("sb_busy_set", 64'(oBusy[0]), 64'h1);
        chk("sb_cnt_set",  64'(oBusyCnt), 64'h1);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd0);
        rd(5'd4, 5'd0);
        chk("sb_data",       64'(oRdata[DW-1:0]), 64'h55);
        chk("sb_busy_reiss", 64'(oBusy[0]), 64'h1);
        chk("sb_cnt_reiss",  64'(oBusyCnt), 64'h1);
        step(1'b0, '0, '0, 1'b1, 5'd4, 32'h55, 1'b0, '0, 5'd4, 5'd0);
        rd(5'd4, 5'd0);
        chk("sb_busy_clr", 64'(oBusy[0]), 64'h0);
        chk("sb_cnt_clr",  64'(oBusyCnt), 64'h0);

        // Same-cycle read of a register being written
        step(1'b1, 5'd12, 32'hCAFE, 1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same", 64'(oRdata[DW-1:0]), 64'hCAFE);
`else
        chk("bypass_same", 64'(oRdata[DW-1:0]), 64'h0);
`endif
        rd(5'd12, 5'd0);
        chk("bypass_next", 64'(oRdata[DW-1:0]), 64'hCAFE);

        // Randomized traffic; a narrow address range makes collisions frequent
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        end
        rd(5'd1, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
